// File: rtl/pc_sequencer_if.sv
// Flow-control strobe bundle between the controller (master) and pc_sequencer (slave).
// Carries the strobes into the sequencer and the PC/status outputs back to the controller.
interface pc_sequencer_if #(
   parameter int PC_W        = 12,
   parameter int OFF_W       = 8,
   parameter int STACK_DEPTH = 4
) ();
   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   logic              start;
   logic              stall;
   logic              halt;
   logic              branch_taken;
   logic [OFF_W-1:0]  branch_off;
   logic              jump;
   logic              call;
   logic              ret;
   logic [PC_W-1:0]   target;
   logic [PC_W-1:0]   pc_out;
   logic              running;
   logic              done;
   logic              err;
   logic [SP_W-1:0]   sp_out;

   modport master (
      output start, stall, halt, branch_taken, branch_off, jump, call, ret, target,
      input  pc_out, running, done, err, sp_out
   );

   modport slave (
      input  start, stall, halt, branch_taken, branch_off, jump, call, ret, target,
      output pc_out, running, done, err, sp_out
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-flow unit: owns the PC, the IDLE/RUN/DONE lifecycle, branch/jump/call/return
// through a pointer-based hardware return stack, and sticky stack-error flagging.
module pc_sequencer #(
   parameter int              PC_W        = 12,
   parameter int              OFF_W       = 8,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}}
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] pc_nxt_s;
   logic [SP_W-1:0] sp_r;
   logic [SP_W-1:0] sp_nxt_s;
   logic            err_r;
   logic            err_nxt_s;
   logic            running_r;
   logic            done_r;
   logic            push_en_s;
   logic [PC_W-1:0] pc_plus1_s;
   logic [PC_W-1:0] off_ext_s;
   logic [IDX_W-1:0] push_idx_s;
   logic [IDX_W-1:0] pop_idx_s;
   logic [PC_W-1:0] stack_r [STACK_DEPTH];

   assign pc_plus1_s = pc_r + PC_W'(1);
   assign off_ext_s  = PC_W'($signed(bus.branch_off));
   assign push_idx_s = IDX_W'(sp_r);
   assign pop_idx_s  = IDX_W'(sp_r - SP_W'(1));

   // Next-state and datapath decode; in RUN exactly one action wins by priority.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      sp_nxt_s    = sp_r;
      err_nxt_s   = err_r;
      push_en_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            pc_nxt_s = RESET_PC;
            if (bus.start) begin
               state_nxt_s = ST_RUN;
               sp_nxt_s    = SP_ZERO;
               err_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.start) begin
               pc_nxt_s  = RESET_PC;
               sp_nxt_s  = SP_ZERO;
               err_nxt_s = 1'b0;
            end else if (bus.stall) begin
               state_nxt_s = ST_RUN;
            end else if (bus.halt) begin
               state_nxt_s = ST_DONE;
            end else if (bus.ret) begin
               if (sp_r != SP_ZERO) begin
                  pc_nxt_s = stack_r[pop_idx_s];
                  sp_nxt_s = sp_r - SP_W'(1);
               end else begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = ST_DONE;
               end
            end else if (bus.call) begin
               if (sp_r != SP_FULL) begin
                  push_en_s = 1'b1;
                  sp_nxt_s  = sp_r + SP_W'(1);
                  pc_nxt_s  = bus.target;
               end else begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = ST_DONE;
               end
            end else if (bus.jump) begin
               pc_nxt_s = bus.target;
            end else if (bus.branch_taken) begin
               pc_nxt_s = pc_plus1_s + off_ext_s;
            end else begin
               pc_nxt_s = pc_plus1_s;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               state_nxt_s = ST_RUN;
               pc_nxt_s    = RESET_PC;
               sp_nxt_s    = SP_ZERO;
               err_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            pc_nxt_s    = RESET_PC;
            sp_nxt_s    = SP_ZERO;
            err_nxt_s   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // PC, stack pointer, error flag and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r      <= RESET_PC;
         sp_r      <= SP_ZERO;
         err_r     <= 1'b0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         pc_r      <= pc_nxt_s;
         sp_r      <= sp_nxt_s;
         err_r     <= err_nxt_s;
         running_r <= (state_nxt_s == ST_RUN);
         done_r    <= (state_nxt_s == ST_DONE);
      end
   end

   // Return-stack storage; contents are don't-care after reset, so only pushes are gated.
   always_ff @(posedge clk) begin
      if (!reset && push_en_s) begin
         stack_r[push_idx_s] <= pc_plus1_s;
      end
   end

   assign bus.pc_out  = pc_r;
   assign bus.running = running_r;
   assign bus.done    = done_r;
   assign bus.err     = err_r;
   assign bus.sp_out  = sp_r;

   pc_sequencer_chk #(
      .SP_W        (SP_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_chk (
      .clk     (clk),
      .reset   (reset),
      .running (running_r),
      .done    (done_r),
      .err     (err_r),
      .sp      (sp_r)
   );
endmodule

// Invariants on the registered status outputs.
module pc_sequencer_chk #(
   parameter int SP_W        = 3,
   parameter int STACK_DEPTH = 4
) (
   input logic            clk,
   input logic            reset,
   input logic            running,
   input logic            done,
   input logic            err,
   input logic [SP_W-1:0] sp
);
   a_run_done_excl: assert property (@(posedge clk) disable iff (reset) !(running && done));
   a_err_in_done:   assert property (@(posedge clk) disable iff (reset) err |-> done);
   a_sp_bound:      assert property (@(posedge clk) disable iff (reset) sp <= SP_W'(STACK_DEPTH));
endmodule
